mix_columns_iter: RTL and testbench



---
 rtl/mix_columns_iter_if.sv | 22 ++
 rtl/mix_columns_iter.sv | 121 ++++++++++++
 tb/tb_mix_columns_iter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mix_columns_iter_if.sv
// Valid/ready bus for the iterative MixColumns stage: the input state with mode bits
// and the output state.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_data;
  logic         in_inv;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;

  modport master (
    output in_valid, in_data, in_inv, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_inv, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns. Each BUSY cycle transforms COLS_PER_CYCLE
// columns in place. Bypass skips straight to DONE for the final round.
module mix_columns_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  mix_columns_iter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       st_q;
  logic [0:127] data_q;
  logic [0:127] data_mixed;
  logic [1:0]   cnt_q;
  logic [2:0]   cnt_sum;
  logic         inv_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column packed as {a0, a1, a2, a3} with a0 in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*(3-i) +: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      if (!inv) begin
        res[8*(3-r) +: 8] = x2[r] ^ x2[(r+1)&3] ^ a[(r+1)&3] ^ a[(r+2)&3] ^ a[(r+3)&3];
      end else begin
        // E*a_r ^ B*a_r+1 ^ D*a_r+2 ^ 9*a_r+3
        res[8*(3-r) +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                          ^ (x8[(r+1)&3] ^ x2[(r+1)&3] ^ a[(r+1)&3])
                          ^ (x8[(r+2)&3] ^ x4[(r+2)&3] ^ a[(r+2)&3])
                          ^ (x8[(r+3)&3] ^ a[(r+3)&3]);
      end
    end
    return res;
  endfunction

  always_comb begin
    data_mixed = data_q;
    col_in     = '0;
    col_out    = '0;
    for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
      for (int r = 0; r < 4; r++) begin
        col_in[8*(3-r) +: 8] = data_q[32*r + 8*((int'(cnt_q) + k) & 3) +: 8];
      end
      col_out = mix_col(col_in, inv_q);
      for (int r = 0; r < 4; r++) begin
        data_mixed[32*r + 8*((int'(cnt_q) + k) & 3) +: 8] = col_out[8*(3-r) +: 8];
      end
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + 3'(COLS_PER_CYCLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      data_q      <= '0;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            inv_q      <= bus.in_inv;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (bus.in_bypass) begin
              st_q        <= StDone;
              out_valid_q <= 1'b1;
            end else begin
              st_q <= StBusy;
            end
          end
        end
        StBusy: begin
          data_q <= data_mixed;
          cnt_q  <= cnt_sum[1:0];
          if (cnt_sum == 3'd4) begin
            st_q        <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            st_q        <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter with one instance per legal COLS_PER_CYCLE.
module tb_mix_columns_iter;

  localparam logic [0:127] FwdIn  = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
  localparam logic [0:127] FwdOut = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;
  localparam logic [0:127] BypIn  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [0:127] RstIn  = 128'hd4000000_d4000000_d4000000_d5000000;
  localparam logic [0:127] RstOut = 128'hd5000000_d5000000_d7000000_d6000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [0:127] in_data   [3];
  logic         in_inv    [3];
  logic         in_bypass [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [0:127] out_data  [3];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_iter_if ifb ();
    mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (.clk(clk), .rst(rst), .bus(ifb));
    assign ifb.in_valid  = in_valid[g];
    assign ifb.in_data   = in_data[g];
    assign ifb.in_inv    = in_inv[g];
    assign ifb.in_bypass = in_bypass[g];
    assign ifb.out_ready = out_ready[g];
    assign in_ready[g]   = ifb.in_ready;
    assign out_valid[g]  = ifb.out_valid;
    assign out_data[g]   = ifb.out_data;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [0:127] ref_mix(input logic [0:127] s, input logic inv,
                                           input logic byp);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [0:127] o;
    if (byp) return s;
    if (inv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc ^= gmul(cf[(j - r) & 3], s[32*j + 8*c +: 8]);
        o[32*r + 8*c +: 8] = acc;
      end
    end
    return o;
  endfunction

  // Full transaction; input lines are scrambled right after accept to show they are ignored.
  task automatic run_xact(input int k, input logic [0:127] d, input logic inv, input logic byp,
                          output int lat, output logic [0:127] res);
    int n;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      tick();
      n++;
    end
    in_valid[k] = 1'b1; in_data[k] = d; in_inv[k] = inv; in_bypass[k] = byp;
    tick();
    in_valid[k] = 1'b0; in_data[k] = ~d; in_inv[k] = ~inv; in_bypass[k] = ~byp;
    lat = 1;
    while (!out_valid[k] && lat < 50) begin
      tick();
      lat++;
    end
    res = out_data[k];
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  logic [0:127] sd [8];
  logic [0:127] se [8];
  logic         si [8];
  logic         sb [8];

  initial begin
    int           lat;
    int           n;
    logic [0:127] res;
    int           exp_lat [3];
    exp_lat[0] = 5; exp_lat[1] = 3; exp_lat[2] = 2;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_inv[k] = 1'b0;
      in_bypass[k] = 1'b0; out_ready[k] = 1'b0;
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid%0d", k), out_valid[k], 1'b0);
      check($sformatf("rst_in_ready%0d", k), in_ready[k], 1'b1);
      check($sformatf("rst_out_data%0d", k), out_data[k], '0);
    end

    // Forward and inverse on every width.
    for (int k = 0; k < 3; k++) begin
      run_xact(k, FwdIn, 1'b0, 1'b0, lat, res);
      check($sformatf("fwd_data%0d", k), res, FwdOut);
      check($sformatf("fwd_lat%0d", k), lat, exp_lat[k]);
      check($sformatf("fwd_idle%0d", k), in_ready[k], 1'b1);
      run_xact(k, FwdOut, 1'b1, 1'b0, lat, res);
      check($sformatf("inv_data%0d", k), res, FwdIn);
      check($sformatf("inv_lat%0d", k), lat, exp_lat[k]);
    end

    // Bypass, in_inv irrelevant.
    run_xact(0, BypIn, 1'b1, 1'b1, lat, res);
    check("byp_data_inv1", res, BypIn);
    check("byp_lat_inv1", lat, 1);
    run_xact(1, BypIn, 1'b0, 1'b1, lat, res);
    check("byp_data_inv0", res, BypIn);
    check("byp_lat_inv0", lat, 1);

    // Backpressure on the 4-column instance.
    in_valid[2] = 1'b1; in_data[2] = FwdIn; in_inv[2] = 1'b0; in_bypass[2] = 1'b0;
    tick();
    in_valid[2] = 1'b0;
    n = 1;
    while (!out_valid[2] && n < 50) begin
      tick();
      n++;
    end
    check("bp_lat", n, 2);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid[2], 1'b1);
      check("bp_data", out_data[2], FwdOut);
      check("bp_in_ready", in_ready[2], 1'b0);
      tick();
    end
    out_ready[2] = 1'b1;
    tick();
    out_ready[2] = 1'b0;
    check("bp_release_in_ready", in_ready[2], 1'b1);
    check("bp_release_valid", out_valid[2], 1'b0);

    // Reset after two column updates on the 1-column instance.
    in_valid[0] = 1'b1; in_data[0] = FwdIn; in_inv[0] = 1'b0; in_bypass[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", out_valid[0], 1'b0);
    check("midrst_data", out_data[0], '0);
    check("midrst_in_ready", in_ready[0], 1'b1);
    run_xact(0, RstIn, 1'b0, 1'b0, lat, res);
    check("midrst_next_data", res, RstOut);
    check("midrst_next_lat", lat, 5);

    // Random stream with gaps on the 2-column instance.
    for (int i = 0; i < 8; i++) begin
      sd[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      si[i] = 1'($urandom_range(0, 1));
      sb[i] = ($urandom_range(0, 3) == 0);
      se[i] = ref_mix(sd[i], si[i], sb[i]);
    end
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int   g;
          int   m;
          logic h;
          g = $urandom_range(0, 3);
          repeat (g) tick();
          in_valid[1] = 1'b1; in_data[1] = sd[i]; in_inv[1] = si[i]; in_bypass[1] = sb[i];
          m = 0;
          do begin
            h = in_ready[1];
            tick();
            m++;
          end while (!h && m < 100);
          in_valid[1] = 1'b0;
          in_data[1]  = ~sd[i];
        end
      end
      begin
        int j;
        int cyc;
        j = 0;
        cyc = 0;
        while (j < 8 && cyc < 600) begin
          out_ready[1] = 1'($urandom_range(0, 1));
          if (out_valid[1] && out_ready[1]) begin
            check($sformatf("stream%0d", j), out_data[1], se[j]);
            j++;
          end
          tick();
          cyc++;
        end
        out_ready[1] = 1'b0;
        check("stream_count", j, 8);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
